// File: rtl/fixed_point_div.sv
// fixed_point_div: sequential signed Q(WIDTH-FRAC).FRAC divider.
// Restoring division on magnitudes, one quotient bit per clock (WIDTH+FRAC
// iterations). The result is truncated toward zero and saturated to the
// signed WIDTH-bit range.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   start, a, b        request and operands, accepted only while ready=1
//   ready              idle, can accept a request
//   out                signed quotient, held between done pulses
//   done               one-cycle pulse when out/flags update
//   overflow           quotient saturated (also set on divide-by-zero)
//   div_by_zero        divisor was zero
module fixed_point_div #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int DW = WIDTH + FRAC;   // dividend / quotient width
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  // Saturation limits as magnitudes in the quotient's width.
  localparam logic [DW-1:0] MAG_POS = {{FRAC{1'b0}}, 1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [DW-1:0] MAG_NEG = {{FRAC{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_n;
  logic             sign, a_neg, b_zero;
  logic [WIDTH-1:0] b_mag;
  logic [DW-1:0]    dvd, quo;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] a_mag_in, b_mag_in;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             rem_ge;
  logic [WIDTH-1:0] res;
  logic             res_ov;

  assign ready = (state == IDLE);

  // Unsigned magnitudes: the most negative value maps to 2^(WIDTH-1) exactly.
  assign a_mag_in = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag_in = b[WIDTH-1] ? (~b + 1'b1) : b;

  // The remainder always stays below |b| <= 2^(WIDTH-1), so the shift into
  // WIDTH+1 bits never loses a set bit.
  assign rem_sh  = (rem << 1) | {{WIDTH{1'b0}}, dvd[DW-1]};
  assign rem_ge  = (rem_sh >= {1'b0, b_mag});
  assign rem_sub = rem_sh - {1'b0, b_mag};

  // Result selection from the finished magnitude.
  always_comb begin
    res    = quo[WIDTH-1:0];
    res_ov = 1'b0;
    if (b_zero) begin
      res    = a_neg ? OUT_MIN : OUT_MAX;
      res_ov = 1'b1;
    end else if (!sign && (quo > MAG_POS)) begin
      res    = OUT_MAX;
      res_ov = 1'b1;
    end else if (sign && (quo > MAG_NEG)) begin
      res    = OUT_MIN;
      res_ov = 1'b1;
    end else if (sign) begin
      res    = ~quo[WIDTH-1:0] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = CALC;
      CALC:    if (cnt == CW'(DW-1)) state_n = FINISH;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign        <= 1'b0;
      a_neg       <= 1'b0;
      b_zero      <= 1'b0;
      b_mag       <= '0;
      dvd         <= '0;
      quo         <= '0;
      rem         <= '0;
      cnt         <= '0;
      out         <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= (state == FINISH);
      case (state)
        IDLE: if (start) begin
          sign   <= a[WIDTH-1] ^ b[WIDTH-1];
          a_neg  <= a[WIDTH-1];
          b_zero <= (b == '0);
          b_mag  <= b_mag_in;
          dvd    <= {a_mag_in, {FRAC{1'b0}}};
          quo    <= '0;
          rem    <= '0;
          cnt    <= '0;
        end
        CALC: begin
          dvd <= dvd << 1;
          rem <= rem_ge ? rem_sub : rem_sh;
          quo <= {quo[DW-2:0], rem_ge};
          cnt <= cnt + 1'b1;
        end
        FINISH: begin
          out         <= res;
          overflow    <= res_ov;
          div_by_zero <= b_zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_div.sv
// Directed bench for fixed_point_div: table of hand-computed vectors plus
// handshake, back-to-back and mid-operation reset sequences.
module tb_fixed_point_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        ready, done, overflow, div_by_zero;
  logic [31:0] q;

  int checks = 0;
  int errors = 0;

  fixed_point_div #(.WIDTH(32), .FRAC(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .ready(ready), .out(q), .done(done),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        ov;
    logic        dz;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issue one division, wait for done (bounded) and return results.
  task automatic do_div(input logic [31:0] aa, input logic [31:0] bb,
                        output logic [31:0] o, output logic ov, output logic dz,
                        output int lat, output bit got);
    @(negedge clk);
    chk("ready_before_start", {31'b0, ready}, 32'd1);
    start = 1'b1; a = aa; b = bb;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0; got = 1'b0;
    o = '0; ov = 1'b0; dz = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (done) begin
        got = 1'b1; o = q; ov = overflow; dz = div_by_zero;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] o;
    logic ov, dz;
    int lat, ndone, last_done_k, prev_done;
    bit got;

    vecs[0]  = '{32'h00008000, 32'h00004000, 32'h00020000, 1'b0, 1'b0};
    vecs[1]  = '{32'h00010000, 32'h00030000, 32'h00005555, 1'b0, 1'b0};
    vecs[2]  = '{32'hFFFF0000, 32'h00008000, 32'hFFFE0000, 1'b0, 1'b0};
    vecs[3]  = '{32'hFFFF0000, 32'h00030000, 32'hFFFFAAAB, 1'b0, 1'b0};
    vecs[4]  = '{32'hFFFF0000, 32'hFFFD0000, 32'h00005555, 1'b0, 1'b0};
    vecs[5]  = '{32'h7FFFFFFF, 32'h00008000, 32'h7FFFFFFF, 1'b1, 1'b0};
    vecs[6]  = '{32'h80000000, 32'hFFFF0000, 32'h7FFFFFFF, 1'b1, 1'b0};
    vecs[7]  = '{32'h80000000, 32'h00010000, 32'h80000000, 1'b0, 1'b0};
    vecs[8]  = '{32'h00010000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[9]  = '{32'hFFFF0000, 32'h00000000, 32'h80000000, 1'b1, 1'b1};
    vecs[10] = '{32'h00030000, 32'h00020000, 32'h00018000, 1'b0, 1'b0};
    vecs[11] = '{32'hFFFFFFFF, 32'h00020000, 32'h00000000, 1'b0, 1'b0};
    vecs[12] = '{32'hFFFFFFFF, 32'h00008000, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[13] = '{32'h80000000, 32'h00018000, 32'hAAAAAAAB, 1'b0, 1'b0};
    vecs[14] = '{32'h00000000, 32'hFFFF0000, 32'h00000000, 1'b0, 1'b0};
    vecs[15] = '{32'h00000000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[16] = '{32'h7FFFFFFF, 32'hFFFF8000, 32'h80000000, 1'b1, 1'b0};

    // Reset state
    #12;
    chk("rst_out", q, 32'h0);
    chk("rst_flags", {28'b0, ready, done, overflow, div_by_zero}, 32'h8);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table vectors: result, flags, latency, one-cycle done, held output
    foreach (vecs[i]) begin
      do_div(vecs[i].a, vecs[i].b, o, ov, dz, lat, got);
      chk($sformatf("got_done[%0d]", i), {31'b0, got}, 32'd1);
      chk($sformatf("out[%0d]", i), o, vecs[i].q);
      chk($sformatf("ov[%0d]", i), {31'b0, ov}, {31'b0, vecs[i].ov});
      chk($sformatf("dz[%0d]", i), {31'b0, dz}, {31'b0, vecs[i].dz});
      chk($sformatf("latency[%0d]", i), lat, 32'd49);
      chk($sformatf("ready_at_done[%0d]", i), {31'b0, ready}, 32'd1);
      @(negedge clk);
      chk($sformatf("done_width[%0d]", i), {31'b0, done}, 32'd0);
      chk($sformatf("out_held[%0d]", i), q, vecs[i].q);
    end

    // Start pulses while busy are ignored
    @(negedge clk);
    start = 1'b1; a = 32'h00010000; b = 32'h00030000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ndone = 0; last_done_k = -1;
    for (int k = 1; k <= 120; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin ndone++; last_done_k = k; o = q; end
      if (k == 5 || k == 30) begin start = 1'b1; a = 32'h12345678; b = 32'h00000001; end
      else start = 1'b0;
    end
    chk("busy_start_ndone", ndone, 32'd1);
    chk("busy_start_done_k", last_done_k, 32'd49);
    chk("busy_start_out", o, 32'h00005555);

    // start held high: back-to-back results every 50 cycles
    @(negedge clk);
    start = 1'b1; a = 32'h00030000; b = 32'h00020000;
    @(posedge clk);
    ndone = 0; last_done_k = -1; prev_done = 0;
    for (int k = 1; k <= 175; k++) begin
      @(negedge clk);
      if (k == 140) start = 1'b0;
      if (done) begin
        if (prev_done) chk("b2b_done_width", 32'd2, 32'd1);
        if (last_done_k >= 0) chk("b2b_interval", k - last_done_k, 32'd50);
        chk("b2b_out", q, 32'h00018000);
        ndone++; last_done_k = k;
      end
      prev_done = done;
      @(posedge clk);
    end
    chk("b2b_ndone", ndone, 32'd3);

    // Reset mid-division aborts with no done
    @(negedge clk);
    start = 1'b1; a = 32'h00010000; b = 32'h00030000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out", q, 32'h0);
    chk("abort_flags", {28'b0, ready, done, overflow, div_by_zero}, 32'h8);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 32'd0);
    chk("abort_ready", {31'b0, ready}, 32'd1);
    do_div(32'hFFFF0000, 32'h00030000, o, ov, dz, lat, got);
    chk("post_reset_got", {31'b0, got}, 32'd1);
    chk("post_reset_out", o, 32'hFFFFAAAB);
    chk("post_reset_lat", lat, 32'd49);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
